// File: rtl/mem_access.sv
// MEM-stage data-memory access: store lane steering, load extension, req/ack bus
// handshake with pipeline stall, misalignment and timeout reporting.
module mem_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_m,
    input  logic        mem_write_m,
    input  logic [1:0]  size_m,
    input  logic        unsigned_m,
    input  logic [31:0] addr_m,
    input  logic [31:0] wdata_m,
    output logic        stall_m,
    output logic [31:0] read_data_m,
    output logic [1:0]  err_m,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    // state  | meaning
    // IDLE   | waiting for a load/store; evaluates alignment
    // BUSY   | request on the bus, waiting for ack or timeout
    // DONE   | result/error valid, pipeline released for one cycle
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] WAIT_TC = 8'(TIMEOUT - 1);

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_TOUT  = 2'b10;

    logic [1:0]  state;
    logic [7:0]  wait_cnt;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        load_q;

    logic        access;
    logic        misaligned;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] load_fmt;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign access  = mem_read_m | mem_write_m;
    assign stall_m = ((state == S_IDLE) && access) || (state == S_BUSY);

    always_comb begin
        misaligned = 1'b0;
        be_nxt     = 4'b1111;
        wdata_nxt  = wdata_m;
        case (size_m)
            2'b00: begin
                be_nxt    = 4'b0001 << addr_m[1:0];
                wdata_nxt = {4{wdata_m[7:0]}};
            end
            2'b01: begin
                misaligned = addr_m[0];
                be_nxt     = addr_m[1] ? 4'b1100 : 4'b0011;
                wdata_nxt  = {2{wdata_m[15:0]}};
            end
            default: begin
                misaligned = |addr_m[1:0];
            end
        endcase
        if (mem_read_m) begin
            be_nxt = 4'b1111;
        end
    end

    // Lane selection uses the offset captured at request time, since the
    // bus address has its low bits cleared.
    always_comb begin
        rd_byte  = mem_rdata[8*off_q +: 8];
        rd_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_fmt = mem_rdata;
        case (size_q)
            2'b00:   load_fmt = {{24{~uns_q & rd_byte[7]}}, rd_byte};
            2'b01:   load_fmt = {{16{~uns_q & rd_half[15]}}, rd_half};
            default: load_fmt = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= 8'd0;
            read_data_m <= 32'd0;
            err_m       <= ERR_OK;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_be      <= 4'd0;
            mem_wdata   <= 32'd0;
            off_q       <= 2'd0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (access) begin
                        if (misaligned) begin
                            err_m       <= ERR_ALIGN;
                            read_data_m <= 32'd0;
                            state       <= S_DONE;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= mem_write_m;
                            mem_addr  <= {addr_m[31:2], 2'b00};
                            mem_be    <= be_nxt;
                            mem_wdata <= wdata_nxt;
                            off_q     <= addr_m[1:0];
                            size_q    <= size_m;
                            uns_q     <= unsigned_m;
                            load_q    <= mem_read_m;
                            wait_cnt  <= 8'd0;
                            state     <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        if (load_q) begin
                            read_data_m <= load_fmt;
                        end
                        err_m   <= ERR_OK;
                        mem_req <= 1'b0;
                        state   <= S_DONE;
                    end else if (wait_cnt == WAIT_TC) begin
                        mem_req     <= 1'b0;
                        err_m       <= ERR_TOUT;
                        read_data_m <= 32'd0;
                        state       <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    err_m <= ERR_OK;
                    state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed vector bench for mem_access: table of single accesses plus
// hand-written timeout, wait-state, back-to-back and reset sequences.
module tb_mem_access;

    logic        clk;
    logic        rst_n;
    logic        mem_read_m;
    logic        mem_write_m;
    logic [1:0]  size_m;
    logic        unsigned_m;
    logic [31:0] addr_m;
    logic [31:0] wdata_m;
    logic        stall_m;
    logic [31:0] read_data_m;
    logic [1:0]  err_m;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_chk = 0;
    int n_err = 0;

    mem_access #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read_m  (mem_read_m),
        .mem_write_m (mem_write_m),
        .size_m      (size_m),
        .unsigned_m  (unsigned_m),
        .addr_m      (addr_m),
        .wdata_m     (wdata_m),
        .stall_m     (stall_m),
        .read_data_m (read_data_m),
        .err_m       (err_m),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read_m  = 1'b0;
        mem_write_m = 1'b0;
    endtask

    task automatic drive(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        mem_read_m  = ~wr;
        mem_write_m = wr;
        size_m      = sz;
        unsigned_m  = uns;
        addr_m      = a;
        wdata_m     = wd;
    endtask

    initial begin
        int reqs;
        // wr size uns addr wdata rdata mis be exp_wdata exp_read_data
        vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0, 32'h80FF_0000, 1'b0, 4'b1111, 32'h0, 32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, 32'h80FF_0000, 1'b0, 4'b1111, 32'h0, 32'h0000_0080};
        vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0, 32'h80FF_0000, 1'b0, 4'b1111, 32'h0, 32'hFFFF_80FF};
        vecs[4]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h1234_5678, 32'h0, 1'b0, 4'b0010, 32'h7878_7878, 32'hFFFF_80FF};
        vecs[5]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h1234_5678, 32'h0, 1'b0, 4'b1100, 32'h5678_5678, 32'hFFFF_80FF};
        vecs[6]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'hFFFF_80FF};
        vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0, 32'h1234_F00D, 1'b0, 4'b1111, 32'h0, 32'h0000_F00D};
        vecs[8]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0, 32'h0000_7F00, 1'b0, 4'b1111, 32'h0, 32'h0000_007F};
        vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'h0, 32'h8000_0001, 1'b0, 4'b1111, 32'h0, 32'h8000_0001};
        vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h0000_0003, 32'h1234_5678, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
        vecs[12] = '{1'b1, 2'b00, 1'b0, 32'h0000_001A, 32'h0000_00AB, 32'h0, 1'b0, 4'b0100, 32'hABAB_ABAB, 32'h0};

        rst_n = 1'b0;
        idle_inputs();
        size_m = 2'b00; unsigned_m = 1'b0; addr_m = '0; wdata_m = '0;
        mem_rdata = '0; mem_ack = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   32'(mem_req),   32'h0);
        chk("rst_we",    32'(mem_we),    32'h0);
        chk("rst_addr",  mem_addr,       32'h0);
        chk("rst_be",    32'(mem_be),    32'h0);
        chk("rst_wdata", mem_wdata,      32'h0);
        chk("rst_rdata", read_data_m,    32'h0);
        chk("rst_err",   32'(err_m),     32'h0);
        chk("rst_stall", 32'(stall_m),   32'h0);
        #2 rst_n = 1'b1;
        tick();
        chk("idle_stall", 32'(stall_m), 32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
            #1;
            chk($sformatf("v%0d_stall0", i), 32'(stall_m), 32'h1);
            tick();
            if (vecs[i].mis) begin
                chk($sformatf("v%0d_noreq", i), 32'(mem_req), 32'h0);
                chk($sformatf("v%0d_err", i),   32'(err_m),   32'h1);
                chk($sformatf("v%0d_rd", i),    read_data_m,  32'h0);
                chk($sformatf("v%0d_stall", i), 32'(stall_m), 32'h0);
            end else begin
                chk($sformatf("v%0d_req", i),    32'(mem_req), 32'h1);
                chk($sformatf("v%0d_we", i),     32'(mem_we),  32'(vecs[i].wr));
                chk($sformatf("v%0d_addr", i),   mem_addr,     {vecs[i].addr[31:2], 2'b00});
                chk($sformatf("v%0d_be", i),     32'(mem_be),  32'(vecs[i].be));
                chk($sformatf("v%0d_wdata", i),  mem_wdata,    vecs[i].exp_wd);
                chk($sformatf("v%0d_stall1", i), 32'(stall_m), 32'h1);
                mem_rdata = vecs[i].rdata;
                mem_ack   = 1'b1;
                tick();
                mem_ack = 1'b0;
                chk($sformatf("v%0d_dreq", i),   32'(mem_req), 32'h0);
                chk($sformatf("v%0d_stall2", i), 32'(stall_m), 32'h0);
                chk($sformatf("v%0d_err", i),    32'(err_m),   32'h0);
                chk($sformatf("v%0d_rd", i),     read_data_m,  vecs[i].exp_rd);
            end
            idle_inputs();
            tick();
            chk($sformatf("v%0d_errclr", i), 32'(err_m), 32'h0);
        end

        // Timeout: request held exactly TIMEOUT cycles, then DONE with error.
        drive(1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0);
        mem_rdata = 32'h5555_AAAA;
        reqs = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (!mem_req) break;
            reqs++;
            chk("to_stall_busy", 32'(stall_m), 32'h1);
        end
        chk("to_req_cycles", 32'(reqs), 32'd4);
        chk("to_err", 32'(err_m), 32'h2);
        chk("to_rd", read_data_m, 32'h0);
        chk("to_stall_done", 32'(stall_m), 32'h0);
        idle_inputs();
        mem_ack = 1'b1;
        tick();
        chk("late_ack_req", 32'(mem_req), 32'h0);
        chk("late_ack_err", 32'(err_m),   32'h0);
        tick();
        chk("late_ack_req2", 32'(mem_req), 32'h0);
        chk("late_ack_stall", 32'(stall_m), 32'h0);
        chk("late_ack_rd", read_data_m, 32'h0);
        mem_ack = 1'b0;

        // Two wait states before ack: stall 1,1,1,0.
        drive(1'b0, 2'b00, 1'b1, 32'h0000_0052, 32'h0);
        mem_rdata = 32'h00C3_0000;
        tick();
        chk("ws_busy1", 32'(stall_m), 32'h1);
        tick();
        chk("ws_busy2", 32'(stall_m), 32'h1);
        chk("ws_req2", 32'(mem_req), 32'h1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("ws_stall", 32'(stall_m), 32'h0);
        chk("ws_rd", read_data_m, 32'h0000_00C3);
        chk("ws_err", 32'(err_m), 32'h0);

        // Back-to-back: access still present after DONE gets an IDLE gap.
        mem_rdata = 32'h0102_0304;
        tick();
        chk("b2b_idle_req", 32'(mem_req), 32'h0);
        chk("b2b_idle_stall", 32'(stall_m), 32'h1);
        tick();
        chk("b2b_req", 32'(mem_req), 32'h1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        idle_inputs();
        chk("b2b_rd", read_data_m, 32'h0000_0002);

        // Reset pulse during BUSY drops the request immediately.
        tick();
        drive(1'b1, 2'b10, 1'b0, 32'h0000_0060, 32'h7777_7777);
        tick();
        chk("rstb_req_before", 32'(mem_req), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstb_req_async", 32'(mem_req), 32'h0);
        idle_inputs();
        #1 rst_n = 1'b1;
        tick();
        chk("rstb_stall", 32'(stall_m), 32'h0);
        chk("rstb_req", 32'(mem_req), 32'h0);
        chk("rstb_err", 32'(err_m), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access.md
# mem_access

Data-memory access stage. It sits in the MEM stage directly upstream of the MEM/WB pipeline register, and drives a word-wide data-memory bus with a req/ack handshake. It performs byte-lane steering and byte enables for stores, and sign/zero extension for loads. It stalls the pipeline until each access completes, and flags misaligned or timed-out accesses. Its registered `read_data_m` feeds the MEM/WB register's read-data input.

## Interface
- `TIMEOUT`, default 16: number of BUSY cycles without `mem_ack` before the access aborts with a timeout error. Legal range is 1..255.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `mem_read_m` input, 1 bit: the instruction in MEM is a load.
- `mem_write_m` input, 1 bit: the instruction in MEM is a store. Never high together with `mem_read_m`.
- `size_m` input, 2 bits: access size. 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- `unsigned_m` input, 1 bit: load zero-extends when 1, sign-extends when 0.
- `addr_m` input, 32 bits: byte address (ALU result).
- `wdata_m` input, 32 bits: store data, right-aligned.
- `stall_m` output, 1 bit: to the hazard unit; freezes the F/D/E/M registers.
- `read_data_m` output, 32 bits, registered: formatted load result.
- `err_m` output, 2 bits, registered: 00 = ok, 01 = misaligned, 10 = timeout. Valid only in DONE.
- `mem_req` output, 1 bit, registered: bus request.
- `mem_we` output, 1 bit, registered: bus write enable.
- `mem_addr` output, 32 bits, registered: `{addr_m[31:2], 2'b00}`.
- `mem_be` output, 4 bits, registered: byte enables. Bit i enables `mem_wdata[8i+7:8i]`.
- `mem_wdata` output, 32 bits, registered: lane-steered store data.
- `mem_rdata` input, 32 bits: bus read data. Valid when `mem_ack` = 1.
- `mem_ack` input, 1 bit: bus completion, sampled only in BUSY.

## Operation
- The block is little-endian: byte offset k = `addr_m[1:0]` maps to lane `[8k+7:8k]`.
- An access is any cycle in IDLE with `mem_read_m | mem_write_m`.
- Alignment rules:
  - A half access is misaligned if `addr_m[0]` = 1.
  - A word access is misaligned if `addr_m[1:0]` ≠ 0.
  - Byte accesses are always aligned.
- Store steering:
  - Byte: data is replicated to all four lanes; `mem_be` = `4'b0001 << k`.
  - Half: data is replicated to both halves; `mem_be` = 0011 for k = 0, 1100 for k = 2.
  - Word: `mem_be` = 1111.
  - For loads, `mem_be` is 1111 and `mem_we` is 0.
- Load formatting: select the lane(s) by k, then extend to 32 bits per `unsigned_m`.
- State machine (state register plus an 8-bit wait counter):
  - IDLE:
    - `stall_m` = access (combinational).
    - An aligned access loads `mem_req`=1, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` at the clock edge, clears the counter, and moves to BUSY.
    - A misaligned access issues no request, sets `err_m`=01 and `read_data_m`=0, and moves to DONE.
  - BUSY:
    - `stall_m`=1. Bus outputs are held stable.
    - If `mem_ack`=1: capture the formatted `mem_rdata` into `read_data_m` for a load, or hold it for a store; set `err_m`=00; drop `mem_req`; move to DONE.
    - Else, if the counter equals `TIMEOUT`-1: drop `mem_req`, set `err_m`=10 and `read_data_m`=0, and move to DONE.
    - Otherwise, increment the counter.
  - DONE:
    - `stall_m`=0, so the pipeline advances and MEM/WB captures `read_data_m`.
    - Moves unconditionally to IDLE. Any new access is evaluated in IDLE on the next cycle.
    - `err_m` returns to 00 when leaving DONE.
- `read_data_m` holds its value except where the steps above update it.
- `mem_ack` arriving in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE, counter 0, `read_data_m`=0, `err_m`=00, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0.
- `stall_m` evaluates to 0 with IDLE and no access.
- Assertion of `rst_n` mid-access drops `mem_req` immediately (asynchronously) and abandons the access; no error is reported.
- Zero-wait latency, with the access presented in cycle 0:
  - Cycle 0: IDLE, stall.
  - Cycle 1: BUSY, `mem_req`=1, `mem_ack`=1.
  - Cycle 2: DONE, stall low, and MEM/WB captures at the end of cycle 2.
- An access therefore occupies 3 cycles, plus one extra cycle per BUSY cycle without ack.
- A misaligned access occupies 2 cycles (IDLE, DONE).
- Timeout: `mem_req` is high for exactly `TIMEOUT` cycles, then DONE follows with `err_m`=10.
- Non-memory instructions pass with zero added latency.
- Back-to-back accesses are separated by one IDLE evaluation cycle, and `mem_req` is low for at least one cycle between them.

## Test plan
- Reset checks:
  - Reset: all outputs are zero and `stall_m`=0.
  - Pulsing `rst_n` low while in BUSY: `mem_req` drops within the same cycle, and the next state is IDLE.
- Word load, addr 0x0000_0010, `mem_rdata`=0xDEAD_BEEF, ack in the first BUSY cycle:
  - `mem_addr`=0x10, `mem_be`=1111.
  - `stall_m` pattern is 1,1,0.
  - `read_data_m`=0xDEAD_BEEF in DONE, `err_m`=00.
- Byte loads, addr 0x13, `mem_rdata`=0x80FF_0000:
  - Signed gives `read_data_m`=0xFFFF_FF80.
  - Unsigned gives 0x0000_0080.
  - Half signed at 0x12 gives 0xFFFF_80FF.
- Stores with `wdata_m`=0x1234_5678:
  - Byte at 0x21: `mem_be`=0010, `mem_wdata`=0x7878_7878, `mem_we`=1.
  - Half at 0x22: `mem_be`=1100, `mem_wdata`=0x5678_5678.
- Misaligned word load at 0x06: no `mem_req`; stall for 1 cycle; DONE with `err_m`=01 and `read_data_m`=0.
- `TIMEOUT`=4, ack never asserted: `mem_req` is high for exactly 4 cycles, then DONE with `err_m`=10. A late `mem_ack` during DONE/IDLE is ignored.
